mod4_down_counter_ego1: RTL and testbench
=========================================

# mod4_down_counter_ego1

Synchronous mod-4 down counter for the EGO1 board, counting in the reverse direction of the lab's mod-4 up counter. Button S1 (`x`) is synchronised and debounced against the 100 MHz board clock, and each debounced release steps the 2-bit state down: 00→11→10→01→00. A registered borrow output `z` marks the 00→11 wrap. The state drives the two leftmost LEDs and `z` drives the rightmost LED, the same pin mapping the up-counter lab uses.

## Interface
- `DEBOUNCE_CYCLES`, default 2_000_000: consecutive clock cycles a synchronised input must hold a new level before it is accepted (20 ms at 100 MHz). Must be ≥1.
- `clk`  in  1  100 MHz board clock; all state updates on rising edge.
- `rd`  in  1  reset; asynchronous, active-low.
- `x`  in  1  raw S1 button level; 1 = pressed, asynchronous to `clk`.
- `y2`  out  1  state MSB, registered.
- `y1`  out  1  state LSB, registered.
- `z`  out  1  borrow flag, registered; held between count events.
- `evt`  out  1  one-cycle strobe, high in the cycle after each count event.
- `up`  in  1  direction select; present only with `MOD4_UPDOWN_EN`.

## Operation
- Synchroniser:
  - two flops: `x` → `s1` → `xs`.
  - Both reset to 0.
- Debouncer:
  - Counter `dc`, width $clog2(DEBOUNCE_CYCLES+1); accepted level `xd`, reset 0.
  - If `xs`==`xd`: `dc`←0.
  - Else if `dc`==DEBOUNCE_CYCLES-1: `xd`←`xs` and `dc`←0.
  - Else: `dc`←`dc`+1.
  - Any bounce back to `xd` before acceptance restarts the count from 0.
- Edge detect:
  - `xd_q` is `xd` delayed by one cycle, reset 0.
  - Count event `fall` = `xd_q` & ~`xd`. It fires only on a release; a press produces no event.
- Counter on `fall`, down mode:
  - {y2,y1} ← {y2,y1} − 1 mod 4.
  - `z` ← 1 if the previous state was 00, else 0.
- Between events, `y2`, `y1` and `z` hold their values.
- `evt` ← `fall`, so it is high for exactly one cycle per event.
- Reset values: `y2`=0, `y1`=0, `z`=0, `evt`=0, `s1`=`xs`=`xd`=`xd_q`=0, `dc`=0.

## Timing
- Raw `x` change sampled at edge n:
  - `xs` changes at edge n+1.
  - `xd` changes at edge n+1+DEBOUNCE_CYCLES, provided `x` stays stable.
  - `y2`/`y1`/`z` and `evt` update at edge n+2+DEBOUNCE_CYCLES.
- `evt` falls at the following edge.
- Glitch rejection: a level held for fewer than DEBOUNCE_CYCLES consecutive cycles after `xs` produces no `xd` change and no event.
- Press-release minimum spacing: each level must be held ≥DEBOUNCE_CYCLES cycles to register. Events are at most one per 2·DEBOUNCE_CYCLES cycles.
- Reset mid-operation:
  - `rd` low clears all state immediately, without waiting for `clk`.
  - Any pending debounce is discarded.
  - On `rd` release with S1 held, `xd` rises after debounce and the later release counts normally.
  - No spurious event occurs on reset release, because `xd`=`xd_q`=0.
- Reset release is not internally synchronised; the board reset deassertion is treated as sufficiently slow relative to `clk`.

## Configuration
- `MOD4_UPDOWN_EN` defined:
  - Port `up` exists and is sampled through its own two-flop synchroniser, reset 0.
  - On `fall` with synchronised `up`=1: state +1 mod 4; `z` ← 1 if the previous state was 11 (carry), else 0.
  - On `fall` with synchronised `up`=0: down behaviour as above.
- `MOD4_UPDOWN_EN` not defined: no `up` port; the block counts down only.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4.
- Reset check: `rd`=0 with `x` toggling → `y2 y1`=00, `z`=0, `evt`=0 throughout. Release `rd` → no `evt` within 20 cycles.
- Four clean press/release pairs, each level held 10 cycles:
  - State sequence 11, 10, 01, 00.
  - `z`=1 only after the first event; `z`=0 after events 2–4.
  - Exactly one `evt` pulse per release.
  - Each update lands exactly DEBOUNCE_CYCLES+2 edges after the raw release edge.
- Bounce: press, then release with `x` toggling every 2 cycles for 12 cycles before settling low → exactly one event. No event during the press.
- Short glitch: `x` high for 3 cycles from idle → no `evt`; state unchanged.
- Async reset mid-operation:
  - In state 10 with a release debounce in progress, pulse `rd` low for 1 cycle → state 00 and `z`=0 immediately.
  - The in-flight release produces no event.
- `MOD4_UPDOWN_EN` defined:
  - `up`=1, four releases from 00 → states 01, 10, 11, 00, with `z`=1 only on 11→00.
  - Switch to `up`=0, one release → state 11 with `z`=1.

Source files
------------

// File: rtl/mod4_down_counter_ego1.sv
// mod4_down_counter_ego1: debounced S1 button steps a 2-bit counter on each release.
// Default build counts down (00->11->10->01->00) with a registered borrow flag.
// Define MOD4_UPDOWN_EN to add the `up` port, which selects counting up with a carry flag.
module mod4_down_counter_ego1 #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rd,
  input  logic x,
`ifdef MOD4_UPDOWN_EN
  input  logic up,
`endif
  output logic y2,
  output logic y1,
  output logic z,
  output logic evt
);

  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DCW-1:0] DC_LAST = DCW'(DEBOUNCE_CYCLES - 1);

  logic           r_s1;
  logic           r_xs;
  logic           r_xd;
  logic           r_xd_q;
  logic [DCW-1:0] r_dc;
  logic [1:0]     r_cnt;
  logic           r_z;
  logic           r_evt;

  logic           w_xd_nxt;
  logic [DCW-1:0] w_dc_nxt;
  logic           w_fall;
  logic [1:0]     w_cnt_nxt;
  logic           w_z_nxt;

`ifdef MOD4_UPDOWN_EN
  logic           r_up_s1;
  logic           r_up_s;

  // Two-flop synchroniser for the direction select
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      r_up_s1 <= 1'b0;
      r_up_s  <= 1'b0;
    end else begin
      r_up_s1 <= up;
      r_up_s  <= r_up_s1;
    end
  end
`endif

  // Two-flop synchroniser for the raw button level
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      r_s1 <= 1'b0;
      r_xs <= 1'b0;
    end else begin
      r_s1 <= x;
      r_xs <= r_s1;
    end
  end

  // Debounce: accept a new level only after it persists for DEBOUNCE_CYCLES cycles
  always_comb begin
    w_dc_nxt = r_dc;
    w_xd_nxt = r_xd;
    if (r_xs == r_xd) begin
      w_dc_nxt = '0;
    end else if (r_dc == DC_LAST) begin
      w_xd_nxt = r_xs;
      w_dc_nxt = '0;
    end else begin
      w_dc_nxt = r_dc + DCW'(1);
    end
  end

  // Debouncer state and delayed copy for release detection
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      r_dc   <= '0;
      r_xd   <= 1'b0;
      r_xd_q <= 1'b0;
    end else begin
      r_dc   <= w_dc_nxt;
      r_xd   <= w_xd_nxt;
      r_xd_q <= r_xd;
    end
  end

  // A count event is a falling edge of the accepted level (button release)
  assign w_fall = r_xd_q & ~r_xd;

  // Next counter value and borrow/carry flag; hold between events
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_z_nxt   = r_z;
    if (w_fall) begin
`ifdef MOD4_UPDOWN_EN
      if (r_up_s) begin
        w_cnt_nxt = r_cnt + 2'd1;
        w_z_nxt   = (r_cnt == 2'b11);
      end else
`endif
      begin
        w_cnt_nxt = r_cnt - 2'd1;
        w_z_nxt   = (r_cnt == 2'b00);
      end
    end
  end

  // Counter, flag and event strobe registers
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      r_cnt <= 2'b00;
      r_z   <= 1'b0;
      r_evt <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_z   <= w_z_nxt;
      r_evt <= w_fall;
    end
  end

  assign y2  = r_cnt[1];
  assign y1  = r_cnt[0];
  assign z   = r_z;
  assign evt = r_evt;

endmodule

// File: tb/tb_mod4_down_counter_ego1.sv
// Bench for mod4_down_counter_ego1 with DEBOUNCE_CYCLES=4: window-based model plus directed checks.
module tb_mod4_down_counter_ego1;

  localparam int unsigned D = 4;

  logic clk;
  logic rd;
  logic x;
  logic up;
  logic y2;
  logic y1;
  logic z;
  logic evt;

  int total;
  int bad;
  int dut_evts;
  bit chk_en;

  mod4_down_counter_ego1 #(.DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rd  (rd),
    .x   (x),
`ifdef MOD4_UPDOWN_EN
    .up  (up),
`endif
    .y2  (y2),
    .y1  (y1),
    .z   (z),
    .evt (evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: raw samples of x/up, accepted level, pending release, counter
  bit       x_hist [0:D];
  bit       up_hist [0:1];
  bit       m_xd;
  bit       m_pend;
  int       m_cnt;
  bit       m_z;
  bit       m_evt;

  // Model: the accepted level flips when the last D synchronised samples all disagree with it;
  // one edge after a 1->0 flip, the count steps by +/-1 mod 4.
  initial begin
    m_xd = 0; m_pend = 0; m_cnt = 0; m_z = 0; m_evt = 0;
    for (int j = 0; j <= D; j++) x_hist[j] = 0;
    up_hist[0] = 0; up_hist[1] = 0;
    forever begin
      @(posedge clk or negedge rd);
      if (!rd) begin
        m_xd = 0; m_pend = 0; m_cnt = 0; m_z = 0; m_evt = 0;
        for (int j = 0; j <= D; j++) x_hist[j] = 0;
        up_hist[0] = 0; up_hist[1] = 0;
      end else begin
        bit all_diff;
        bit up_eff;
`ifdef MOD4_UPDOWN_EN
        up_eff = up_hist[1];
`else
        up_eff = 0;
`endif
        m_evt = m_pend;
        if (m_pend) begin
          if (up_eff) begin
            m_z   = (m_cnt == 3);
            m_cnt = (m_cnt + 1) % 4;
          end else begin
            m_z   = (m_cnt == 0);
            m_cnt = (m_cnt + 3) % 4;
          end
        end
        m_pend = 0;
        all_diff = 1;
        for (int j = 1; j <= D; j++) if (x_hist[j] == m_xd) all_diff = 0;
        if (all_diff) begin
          m_pend = m_xd;
          m_xd   = !m_xd;
        end
        for (int j = D; j >= 1; j--) x_hist[j] = x_hist[j-1];
        x_hist[0]  = x;
        up_hist[1] = up_hist[0];
        up_hist[0] = up;
      end
    end
  end

  // Compare DUT outputs to the model on every falling clock edge
  initial begin
    dut_evts = 0;
    forever begin
      @(negedge clk);
      if (evt) dut_evts++;
      if (chk_en) begin
        total++;
        if ({y2, y1, z, evt} != {2'(m_cnt), m_z, m_evt}) begin
          bad++;
          $display("FAIL model t=%0t got y=%b%b z=%b evt=%b want y=%0d z=%b evt=%b",
                   $time, y2, y1, z, evt, m_cnt, m_z, m_evt);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Press, hold, release; checks the event lands exactly D+2 edges after the release is sampled
  task automatic press_release(input int hold, input int exp_y, input int exp_z, input string tag);
    int e0;
    x = 1'b1;
    step(hold);
    e0 = dut_evts;
    x = 1'b0;
    step(D + 2);
    check({tag, "_evt_early"}, int'(evt), 0);
    step(1);
    check({tag, "_evt_on_time"}, int'(evt), 1);
    check({tag, "_state"}, int'({y2, y1}), exp_y);
    check({tag, "_z"}, int'(z), exp_z);
    step(hold - D - 3);
    check({tag, "_one_evt"}, dut_evts - e0, 1);
  endtask

  initial begin
    int e0;
    total = 0; bad = 0; chk_en = 0;
    rd = 1'b0; x = 1'b0; up = 1'b0;

    // Reset held with x toggling: everything stays cleared
    #1 chk_en = 1;
    for (int i = 0; i < 6; i++) begin
      x = ~x;
      step(1);
    end
    check("rst_state", int'({y2, y1, z, evt}), 0);
    x = 1'b0;
    rd = 1'b1;
    e0 = dut_evts;
    step(20);
    check("rst_release_no_evt", dut_evts - e0, 0);

    // Four clean press/release pairs: 11,10,01,00 with borrow only on the wrap
    press_release(10, 3, 1, "clean1");
    press_release(10, 2, 0, "clean2");
    press_release(10, 1, 0, "clean3");
    press_release(10, 0, 0, "clean4");

    // Bouncy release: exactly one event, none during the press
    e0 = dut_evts;
    x = 1'b1;
    step(10);
    check("bounce_press_no_evt", dut_evts - e0, 0);
    for (int i = 0; i < 6; i++) begin
      x = ~x;
      step(2);
    end
    x = 1'b0;
    step(12);
    check("bounce_one_evt", dut_evts - e0, 1);
    check("bounce_state", int'({y2, y1}), 3);
    check("bounce_z", int'(z), 1);

    // Short glitch: 3 cycles high is too short to be accepted
    e0 = dut_evts;
    x = 1'b1;
    step(3);
    x = 1'b0;
    step(15);
    check("glitch_no_evt", dut_evts - e0, 0);
    check("glitch_state", int'({y2, y1}), 3);

    // Reach state 10, then reset during a release debounce
    press_release(10, 2, 0, "pre_rst");
    x = 1'b1;
    step(10);
    x = 1'b0;
    step(3);
    e0 = dut_evts;
    rd = 1'b0;
    #1;
    check("async_rst_state", int'({y2, y1}), 0);
    check("async_rst_z", int'(z), 0);
    @(posedge clk);
    #2 rd = 1'b1;
    step(20);
    check("async_rst_no_evt", dut_evts - e0, 0);
    check("async_rst_hold", int'({y2, y1}), 0);

`ifdef MOD4_UPDOWN_EN
    // Count up with carry on 11->00, then one step down with borrow
    up = 1'b1;
    step(5);
    press_release(10, 1, 0, "up1");
    press_release(10, 2, 0, "up2");
    press_release(10, 3, 0, "up3");
    press_release(10, 0, 1, "up4");
    up = 1'b0;
    step(5);
    press_release(10, 3, 1, "down_after_up");
`endif

    step(2);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
